// File: rtl/issue_fu_arbiter.sv
// Purpose: round-robin arbiter sharing one in-order, variable-latency FU among NR_REQ issue ports.
// Latency: issue path is combinational (0 cycles); writeback is registered (result at edge N -> wb at N+1).
// Backpressure: req_ready_o follows credit & fu_ready_i; credit drops when cnt+dcnt reaches MAX_OUTSTANDING.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   flush_i                drop every in-flight transaction (results are swallowed on return)
//   req_valid_i/_trans_id_i/_data_i, req_ready_o   per-port issue handshake
//   fu_valid_o/fu_data_o/fu_ready_i                issue to the shared FU
//   fu_result_valid_i/fu_result_i                  in-order FU results
//   wb_valid_o/wb_trans_id_o/wb_data_o             registered writeback
//   outstanding_o          live (non-discarded) transaction count
module issue_fu_arbiter #(
  parameter int unsigned NR_REQ          = 2,
  parameter int unsigned TRANS_ID_BITS   = 3,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     flush_i,
  input  logic [NR_REQ-1:0]                        req_valid_i,
  input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]     req_trans_id_i,
  input  logic [NR_REQ-1:0][DATA_W-1:0]            req_data_i,
  output logic [NR_REQ-1:0]                        req_ready_o,
  output logic                                     fu_valid_o,
  output logic [DATA_W-1:0]                        fu_data_o,
  input  logic                                     fu_ready_i,
  input  logic                                     fu_result_valid_i,
  input  logic [DATA_W-1:0]                        fu_result_i,
  output logic                                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0]                 wb_trans_id_o,
  output logic [DATA_W-1:0]                        wb_data_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o
);

  localparam int unsigned PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int unsigned AW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW    = $clog2(MAX_OUTSTANDING + 1);

  // State
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [CW-1:0]            dcnt_q, dcnt_d;
  logic [TRANS_ID_BITS-1:0] fifo_q [MAX_OUTSTANDING];
  logic [TRANS_ID_BITS-1:0] fifo_d [MAX_OUTSTANDING];
  logic                     wb_valid_q, wb_valid_d;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_q, wb_trans_id_d;
  logic [DATA_W-1:0]        wb_data_q, wb_data_d;

  // Combinational
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_found;
  logic [PTR_W-1:0] ptr_nxt;
  logic [CW:0]      occupancy;
  logic             credit;
  logic             handshake;
  logic             res_live;
  logic             res_drop;

  function automatic logic [AW-1:0] fifo_inc(input logic [AW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + AW'(1);
  endfunction

  // Rotating-priority scan: first valid port at or after ptr, wrapping.
  always_comb begin : arb
    int unsigned idx;
    logic [PTR_W-1:0] cand;
    idx       = 0;
    cand      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NR_REQ) idx = idx - NR_REQ;
      cand = PTR_W'(idx);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign ptr_nxt = (32'(gnt_idx) == NR_REQ - 1) ? '0 : gnt_idx + PTR_W'(1);

  // Credit uses only registered counts and flush, so a returning result
  // never feeds the issue path combinationally. Discarded results still
  // occupy the FU, hence dcnt counts against the limit.
  assign occupancy = {1'b0, cnt_q} + {1'b0, dcnt_q};
  assign credit    = rst_ni & ~flush_i & (occupancy < (CW+1)'(MAX_OUTSTANDING));

  assign fu_valid_o = (|req_valid_i) & credit;
  assign fu_data_o  = req_data_i[gnt_idx];
  assign handshake  = fu_valid_o & fu_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (credit && fu_ready_i && gnt_found) req_ready_o[gnt_idx] = 1'b1;
  end

  // Results go to discarded transactions first (they are older), then to live ones.
  assign res_drop = fu_result_valid_i & (dcnt_q != '0);
  assign res_live = fu_result_valid_i & (dcnt_q == '0) & (cnt_q != '0);

  always_comb begin
    ptr_d         = handshake ? ptr_nxt : ptr_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_d        = fifo_q;
    cnt_d         = cnt_q + CW'(handshake) - CW'(res_live);
    dcnt_d        = dcnt_q - CW'(res_drop);
    wb_valid_d    = res_live & ~flush_i;
    wb_trans_id_d = wb_trans_id_q;
    wb_data_d     = wb_data_q;

    if (handshake) begin
      fifo_d[wr_ptr_q] = req_trans_id_i[gnt_idx];
      wr_ptr_d         = fifo_inc(wr_ptr_q);
    end
    if (res_live) begin
      rd_ptr_d = fifo_inc(rd_ptr_q);
    end
    if (res_live && !flush_i) begin
      wb_trans_id_d = fifo_q[rd_ptr_q];
      wb_data_d     = fu_result_i;
    end

    // Everything still live becomes a discard, less whatever returned this cycle.
    if (flush_i) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      dcnt_d   = dcnt_q + cnt_q - CW'(res_live) - CW'(res_drop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      dcnt_q        <= '0;
      wb_valid_q    <= 1'b0;
      wb_trans_id_q <= '0;
      wb_data_q     <= '0;
    end else begin
      ptr_q         <= ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      dcnt_q        <= dcnt_d;
      wb_valid_q    <= wb_valid_d;
      wb_trans_id_q <= wb_trans_id_d;
      wb_data_q     <= wb_data_d;
    end
  end

  // ID storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end

  assign wb_valid_o    = wb_valid_q;
  assign wb_trans_id_o = wb_trans_id_q;
  assign wb_data_o     = wb_data_q;
  assign outstanding_o = cnt_q;

  // A result with nothing in flight means the FU broke protocol; it is ignored above.
  result_without_txn: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fu_result_valid_i |-> (cnt_q != '0 || dcnt_q != '0));

endmodule

// File: tb/tb_issue_fu_arbiter.sv
module tb_issue_fu_arbiter;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [1:0]       req_valid;
  logic [1:0][2:0]  req_tid;
  logic [1:0][63:0] req_data;
  logic [1:0]       req_ready;
  logic             fu_valid;
  logic [63:0]      fu_data;
  logic             fu_ready;
  logic             res_valid;
  logic [63:0]      res;
  logic             wb_valid;
  logic [2:0]       wb_tid;
  logic [63:0]      wb_data;
  logic [2:0]       outstanding;

  int n_checks = 0;
  int n_fail   = 0;

  issue_fu_arbiter #(
    .NR_REQ(2), .TRANS_ID_BITS(3), .DATA_W(64), .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_trans_id_i(req_tid), .req_data_i(req_data),
    .req_ready_o(req_ready), .fu_valid_o(fu_valid), .fu_data_o(fu_data),
    .fu_ready_i(fu_ready), .fu_result_valid_i(res_valid), .fu_result_i(res),
    .wb_valid_o(wb_valid), .wb_trans_id_o(wb_tid), .wb_data_o(wb_data),
    .outstanding_o(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; req_valid = 2'b11; fu_ready = 1'b1; res_valid = 1'b0;
    req_tid[0] = 3'd1; req_tid[1] = 3'd2; req_data[0] = 64'h1; req_data[1] = 64'h2; res = '0;
    #1;
    n_checks++; if (fu_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fu_valid: got %b want 0", fu_valid); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
    tick(); tick();
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
    n_checks++; if (wb_tid !== 3'd0) begin n_fail++; $display("FAIL rst_wb_tid: got %0d want 0", wb_tid); end
    n_checks++; if (wb_data !== 64'h0) begin n_fail++; $display("FAIL rst_wb_data: got %h want 0", wb_data); end
    rst_n = 1'b1; req_valid = 2'b00;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    req_tid[0] = 3'd1; req_tid[1] = 3'd2;
    req_data[0] = 64'h1111; req_data[1] = 64'h2222;
    req_valid = 2'b11; fu_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_checks++; if (fu_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid%0d: got %b want 1", k, fu_valid); end
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready%0d: got %b want %b", k, req_ready, exp_rdy); end
      n_checks++; if (fu_data !== ((k % 2 == 0) ? 64'h1111 : 64'h2222)) begin
        n_fail++; $display("FAIL rr_data%0d: got %h want %h", k, fu_data, (k % 2 == 0) ? 64'h1111 : 64'h2222); end
      tick();
    end
    req_valid = 2'b00;
    n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL rr_outstanding: got %0d want 4", outstanding); end
    for (int k = 0; k < 4; k++) begin
      res_valid = 1'b1; res = 64'h100 + 64'(k);
      tick();
      n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL rr_wb_valid%0d: got %b want 1", k, wb_valid); end
      n_checks++; if (wb_tid !== ((k % 2 == 0) ? 3'd1 : 3'd2)) begin
        n_fail++; $display("FAIL rr_wb_tid%0d: got %0d want %0d", k, wb_tid, (k % 2 == 0) ? 1 : 2); end
      n_checks++; if (wb_data !== 64'h100 + 64'(k)) begin n_fail++; $display("FAIL rr_wb_data%0d: got %h want %h", k, wb_data, 64'h100 + 64'(k)); end
      n_checks++; if (outstanding !== 3'(3 - k)) begin n_fail++; $display("FAIL rr_drain_cnt%0d: got %0d want %0d", k, outstanding, 3 - k); end
    end
    res_valid = 1'b0;
    tick();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rr_wb_idle: got %b want 0", wb_valid); end
  endtask

  task automatic test_full();
    req_valid = 2'b01; fu_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      req_tid[0] = 3'(k); req_data[0] = 64'(k);
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL full_issue%0d: got %b want 01", k, req_ready); end
      tick();
    end
    req_tid[0] = 3'd5; req_data[0] = 64'h5;
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL full_ready: got %b want 00", req_ready); end
    n_checks++; if (fu_valid !== 1'b0) begin n_fail++; $display("FAIL full_fu_valid: got %b want 0", fu_valid); end
    n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_outstanding: got %0d want 4", outstanding); end
    res_valid = 1'b1; res = 64'hF1;
    tick();
    res_valid = 1'b0;
    #1;
    n_checks++; if (wb_valid !== 1'b1 || wb_tid !== 3'd1) begin
      n_fail++; $display("FAIL full_wb: got valid=%b tid=%0d want valid=1 tid=1", wb_valid, wb_tid); end
    n_checks++; if (wb_data !== 64'hF1) begin n_fail++; $display("FAIL full_wb_data: got %h want f1", wb_data); end
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL full_credit_back: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_refill: got %0d want 4", outstanding); end
    for (int k = 0; k < 4; k++) begin
      res_valid = 1'b1; res = 64'hF2 + 64'(k);
      tick();
      n_checks++; if (wb_valid !== 1'b1 || wb_tid !== 3'(k + 2)) begin
        n_fail++; $display("FAIL full_drain%0d: got valid=%b tid=%0d want valid=1 tid=%0d", k, wb_valid, wb_tid, k + 2); end
    end
    res_valid = 1'b0;
    tick();
  endtask

  task automatic test_order();
    req_valid = 2'b01; fu_ready = 1'b1;
    req_tid[0] = 3'd5; req_data[0] = 64'h50;
    tick();
    req_tid[0] = 3'd6; req_data[0] = 64'h60;
    tick();
    n_checks++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL ord_cnt_pre: got %0d want 2", outstanding); end
    req_tid[0] = 3'd7; req_data[0] = 64'h70;
    res_valid = 1'b1; res = 64'h55;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL ord_ready_sim: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    n_checks++; if (wb_valid !== 1'b1 || wb_tid !== 3'd5 || wb_data !== 64'h55) begin
      n_fail++; $display("FAIL ord_wb5: got valid=%b tid=%0d data=%h want 1/5/55", wb_valid, wb_tid, wb_data); end
    n_checks++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL ord_cnt_sim: got %0d want 2", outstanding); end
    res = 64'h66;
    tick();
    n_checks++; if (wb_valid !== 1'b1 || wb_tid !== 3'd6 || wb_data !== 64'h66) begin
      n_fail++; $display("FAIL ord_wb6: got valid=%b tid=%0d data=%h want 1/6/66", wb_valid, wb_tid, wb_data); end
    res = 64'h77;
    tick();
    n_checks++; if (wb_valid !== 1'b1 || wb_tid !== 3'd7 || wb_data !== 64'h77) begin
      n_fail++; $display("FAIL ord_wb7: got valid=%b tid=%0d data=%h want 1/7/77", wb_valid, wb_tid, wb_data); end
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL ord_cnt_end: got %0d want 0", outstanding); end
    res_valid = 1'b0;
    tick();
  endtask

  // Pointer sits at port 1 here (the last three grants all went to port 0).
  task automatic test_stall();
    req_tid[0] = 3'd3; req_tid[1] = 3'd4;
    req_data[0] = 64'hAAAA; req_data[1] = 64'hBBBB;
    req_valid = 2'b11; fu_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (fu_valid !== 1'b1 || req_ready !== 2'b00) begin
        n_fail++; $display("FAIL stall_hs%0d: got valid=%b ready=%b want 1/00", k, fu_valid, req_ready); end
      n_checks++; if (fu_data !== 64'hBBBB) begin n_fail++; $display("FAIL stall_data%0d: got %h want bbbb", k, fu_data); end
      tick();
      n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL stall_push%0d: got %0d want 0", k, outstanding); end
    end
    fu_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL stall_release: got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    n_checks++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL stall_cnt: got %0d want 1", outstanding); end
    res_valid = 1'b1; res = 64'hB0;
    tick();
    res_valid = 1'b0;
    n_checks++; if (wb_valid !== 1'b1 || wb_tid !== 3'd4) begin
      n_fail++; $display("FAIL stall_wb: got valid=%b tid=%0d want 1/4", wb_valid, wb_tid); end
    tick();
  endtask

  task automatic test_flush();
    req_valid = 2'b01; fu_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      req_tid[0] = 3'(k); req_data[0] = 64'(k);
      tick();
    end
    n_checks++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL fl_cnt_pre: got %0d want 3", outstanding); end
    flush = 1'b1;
    #1;
    n_checks++; if (fu_valid !== 1'b0 || req_ready !== 2'b00) begin
      n_fail++; $display("FAIL fl_no_issue: got valid=%b ready=%b want 0/00", fu_valid, req_ready); end
    tick();
    flush = 1'b0; req_valid = 2'b00;
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL fl_cnt_post: got %0d want 0", outstanding); end
    for (int k = 0; k < 3; k++) begin
      res_valid = 1'b1; res = 64'hD0 + 64'(k);
      tick();
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL fl_drop%0d: got %b want 0", k, wb_valid); end
    end
    res_valid = 1'b0;
    req_valid = 2'b01; req_tid[0] = 3'd2; req_data[0] = 64'h2;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL fl_reissue: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    res_valid = 1'b1; res = 64'h2222_0002;
    tick();
    res_valid = 1'b0;
    n_checks++; if (wb_valid !== 1'b1 || wb_tid !== 3'd2 || wb_data !== 64'h2222_0002) begin
      n_fail++; $display("FAIL fl_wb: got valid=%b tid=%0d data=%h want 1/2/22220002", wb_valid, wb_tid, wb_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01; fu_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      req_tid[0] = 3'(k); tick();
    end
    req_valid = 2'b00; flush = 1'b1;
    tick();
    flush = 1'b0;
    res_valid = 1'b1; res = 64'hE0;
    tick(); tick();
    res_valid = 1'b0;
    req_valid = 2'b01;
    req_tid[0] = 3'd4; tick();
    req_tid[0] = 3'd5; tick();
    req_valid = 2'b00;
    n_checks++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL rm_cnt_pre: got %0d want 2", outstanding); end
    rst_n = 1'b0; req_valid = 2'b01;
    #1;
    n_checks++; if (fu_valid !== 1'b0) begin n_fail++; $display("FAIL rm_fu_valid: got %b want 0", fu_valid); end
    tick();
    rst_n = 1'b1; req_valid = 2'b00;
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rm_cnt: got %0d want 0", outstanding); end
    n_checks++; if (wb_valid !== 1'b0 || wb_tid !== 3'd0 || wb_data !== 64'h0) begin
      n_fail++; $display("FAIL rm_wb: got valid=%b tid=%0d data=%h want 0/0/0", wb_valid, wb_tid, wb_data); end
    // A full set of four issues only fits if the stale discard count was cleared.
    req_valid = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      req_tid[0] = 3'(k);
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rm_issue%0d: got %b want 01", k, req_ready); end
      tick();
    end
    req_valid = 2'b00;
    n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL rm_cnt_full: got %0d want 4", outstanding); end
    for (int k = 1; k <= 4; k++) begin
      res_valid = 1'b1; res = 64'hC0 + 64'(k);
      tick();
      n_checks++; if (wb_valid !== 1'b1 || wb_tid !== 3'(k) || wb_data !== 64'hC0 + 64'(k)) begin
        n_fail++; $display("FAIL rm_wb%0d: got valid=%b tid=%0d data=%h want 1/%0d/%h", k, wb_valid, wb_tid, wb_data, k, 64'hC0 + 64'(k)); end
    end
    res_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_full();
    test_order();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
